// File: rtl/axis_lrelu_seq.sv
// Per-channel scale, shift and leaky-ReLU over AXI-Stream, with a config frame ahead of each data frame.
// Latency: 2 cycles from slave handshake to m_axis_tvalid (multiply stage, then shift/leak/saturate stage).
// Backpressure: the whole pipeline stalls on !m_axis_tready; the slave side is closed while a frame drains.
module axis_lrelu_seq #(
    parameter int CHANNELS          = 4,
    parameter int WORD_WIDTH_IN     = 16,
    parameter int WORD_WIDTH_OUT    = 8,
    parameter int WORD_WIDTH_CONFIG = 8,
    parameter int TUSER_WIDTH       = 8,
    parameter int CFG_BEATS_3X3     = 3,
    parameter int CFG_BEATS_1X1     = 1,
    parameter int SHIFT             = 4,
    parameter int ALPHA_SHIFT       = 3,
    parameter int INDEX_IS_3X3      = 0,
    parameter int INDEX_IS_RELU     = 1
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [CHANNELS*WORD_WIDTH_IN-1:0]   s_axis_tdata,
    input  logic [TUSER_WIDTH-1:0]              s_axis_tuser,
    input  logic                                s_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [CHANNELS*WORD_WIDTH_OUT-1:0]  m_axis_tdata,
    output logic                                m_axis_tlast
);

    localparam int WI    = WORD_WIDTH_IN;
    localparam int WO    = WORD_WIDTH_OUT;
    localparam int WC    = WORD_WIDTH_CONFIG;
    localparam int PW    = WI + WC;
    localparam int DEPTH = (CFG_BEATS_3X3 > CFG_BEATS_1X1) ? CFG_BEATS_3X3 : CFG_BEATS_1X1;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [1:0] CFG_HDR  = 2'd0;
    localparam logic [1:0] CFG_BODY = 2'd1;
    localparam logic [1:0] PASS     = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    localparam logic signed [PW-1:0] OMAX = {{(PW-WO+1){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [PW-1:0] OMIN = {{(PW-WO+1){1'b1}}, {(WO-1){1'b0}}};

    typedef struct packed {
        logic vld;
        logic last;
        logic relu;
    } meta_t;

    logic [1:0]               state, state_nxt;
    logic                     mode_3x3, mode_relu;
    logic [CW-1:0]            nbeats, wr_addr, rd_addr;
    logic [CW-1:0]            last_row, hdr_nbeats;
    logic                     hdr_is_3x3;
    logic [1:0]               inflight, inflight_nxt;
    logic [CHANNELS*WC-1:0]   cfg_ram [DEPTH];
    logic [CHANNELS*WC-1:0]   cfg_word, scale_row;

    logic                     pipe_en, s_hs, s_data_hs, m_hs;
    meta_t                    s1_meta;
    logic [CHANNELS*PW-1:0]   s1_prod, s1_prod_nxt;
    logic                     m_vld, m_last;
    logic [CHANNELS*WO-1:0]   m_dat, m_dat_nxt;
    logic                     unused_bits;

    function automatic logic [PW-1:0] mul_word(input logic [WI-1:0] x, input logic [WC-1:0] s);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] se;
        xe = {{WC{x[WI-1]}}, x};
        se = {{WI{s[WC-1]}}, s};
        return xe * se;
    endfunction

    function automatic logic [WO-1:0] act_word(input logic [PW-1:0] p, input logic relu);
        logic signed [PW-1:0] q;
        q = $signed(p) >>> SHIFT;
        if (relu && q[PW-1]) begin
            q = q >>> ALPHA_SHIFT;
        end
        if (q > OMAX) begin
            return OMAX[WO-1:0];
        end else if (q < OMIN) begin
            return OMIN[WO-1:0];
        end
        return q[WO-1:0];
    endfunction

    // A full output register only blocks the pipe when the sink refuses it.
    assign pipe_en       = !m_vld || m_axis_tready;
    assign s_axis_tready = aresetn && (state != DRAIN) && pipe_en;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign s_data_hs     = s_hs && (state == PASS);
    assign m_hs          = m_vld && m_axis_tready;

    assign hdr_is_3x3    = s_axis_tuser[INDEX_IS_3X3];
    assign hdr_nbeats    = hdr_is_3x3 ? CW'(CFG_BEATS_3X3) : CW'(CFG_BEATS_1X1);
    assign last_row      = nbeats - CW'(1);
    assign scale_row     = cfg_ram[rd_addr[AW-1:0]];

    assign m_axis_tvalid = m_vld;
    assign m_axis_tdata  = m_dat;
    assign m_axis_tlast  = m_last;

    // mode_3x3 is only kept for observability; other tuser bits carry no meaning here.
    assign unused_bits   = ^{mode_3x3, s_axis_tuser};

    always_comb begin
        cfg_word = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            cfg_word[c*WC +: WC] = s_axis_tdata[c*WI +: WC];
        end
    end

    always_comb begin
        s1_prod_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            s1_prod_nxt[c*PW +: PW] = mul_word(s_axis_tdata[c*WI +: WI], scale_row[c*WC +: WC]);
        end
    end

    always_comb begin
        m_dat_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            m_dat_nxt[c*WO +: WO] = act_word(s1_prod[c*PW +: PW], s1_meta.relu);
        end
    end

    always_comb begin
        inflight_nxt = inflight + {1'b0, s_data_hs} - {1'b0, m_hs};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CFG_HDR: begin
                if (s_hs) begin
                    state_nxt = (hdr_nbeats > CW'(1)) ? CFG_BODY : PASS;
                end
            end
            CFG_BODY: begin
                if (s_hs && (wr_addr == last_row)) begin
                    state_nxt = PASS;
                end
            end
            PASS: begin
                if (s_data_hs && s_axis_tlast) begin
                    state_nxt = DRAIN;
                end
            end
            default: begin
                if (inflight_nxt == 2'd0) begin
                    state_nxt = CFG_HDR;
                end
            end
        endcase
    end

    // Scale rows are not reset; a fresh config frame always precedes their use.
    always_ff @(posedge aclk) begin
        if (s_hs && (state == CFG_HDR)) begin
            cfg_ram[0] <= cfg_word;
        end else if (s_hs && (state == CFG_BODY)) begin
            cfg_ram[wr_addr[AW-1:0]] <= cfg_word;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= CFG_HDR;
            mode_3x3  <= 1'b0;
            mode_relu <= 1'b0;
            nbeats    <= '0;
            wr_addr   <= '0;
            rd_addr   <= '0;
            inflight  <= 2'd0;
        end else begin
            state    <= state_nxt;
            inflight <= inflight_nxt;
            case (state)
                CFG_HDR: begin
                    if (s_hs) begin
                        mode_3x3  <= hdr_is_3x3;
                        mode_relu <= s_axis_tuser[INDEX_IS_RELU];
                        nbeats    <= hdr_nbeats;
                        wr_addr   <= CW'(1);
                        rd_addr   <= '0;
                    end
                end
                CFG_BODY: begin
                    if (s_hs) begin
                        wr_addr <= wr_addr + CW'(1);
                        if (wr_addr == last_row) begin
                            rd_addr <= '0;
                        end
                    end
                end
                PASS: begin
                    if (s_data_hs) begin
                        rd_addr <= (rd_addr == last_row) ? '0 : rd_addr + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Each beat carries its own leak flag so a stalled beat keeps the mode it was accepted under.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s1_meta <= '0;
            s1_prod <= '0;
            m_vld   <= 1'b0;
            m_last  <= 1'b0;
            m_dat   <= '0;
        end else if (pipe_en) begin
            s1_meta.vld  <= s_data_hs;
            s1_meta.last <= s_data_hs && s_axis_tlast;
            s1_meta.relu <= mode_relu;
            s1_prod      <= s1_prod_nxt;
            m_vld        <= s1_meta.vld;
            m_last       <= s1_meta.last;
            m_dat        <= m_dat_nxt;
        end
    end

endmodule

// File: tb/tb_axis_lrelu_seq.sv
// Bench for axis_lrelu_seq: table-driven 1x1 frames, 3x3 row wrap, backpressure, drain and mid-frame reset.
module tb_axis_lrelu_seq;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tuser = '0;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;

    always #5 aclk = ~aclk;

    axis_lrelu_seq dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic        last;
    } exp_t;

    typedef struct {
        logic [7:0]  user;
        int          scale;
        logic [63:0] x;
        logic [31:0] y;
    } vec_t;

    exp_t        sb[$];
    exp_t        cur_exp = '0;
    exp_t        mon_e;
    logic        cur_is_data = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          in_cnt = 0;
    int          out_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat = '0;
    logic        prev_last = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] pin(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] pout(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic int ref_y(input int x, input int s, input bit relu);
        int q;
        q = (x * s) >>> 4;
        if (relu && q < 0) q = q >>> 3;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    // Scoreboard: push on accepted data beats, pop on output handshakes, watch held outputs.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_stall && m_axis_tvalid)
                check("hold_stable", {m_axis_tlast, m_axis_tdata}, {prev_last, prev_dat});
            if (m_axis_tvalid && m_axis_tready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h, expected no output", m_axis_tdata);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_beat", {m_axis_tlast, m_axis_tdata}, {mon_e.last, mon_e.dat});
                end
            end
            if (s_axis_tvalid && s_axis_tready && cur_is_data) begin
                sb.push_back(cur_exp);
                in_cnt++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_dat   = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] u, input logic l,
                             input logic is_data, input exp_t e);
        int   n;
        logic acc;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        cur_is_data   = is_data;
        cur_exp       = e;
        s_axis_tvalid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge aclk);
            acc = s_axis_tready;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got tready=0 for %0d cycles, expected acceptance", n);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        cur_is_data   = 1'b0;
    endtask

    task automatic send_cfg(input logic [7:0] u, input int s, input logic l);
        send_beat(pin(s, s, s, s), u, l, 1'b0, '0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_axis_tvalid) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        @(posedge aclk);
        #1;
    endtask

    vec_t        vecs[5];
    logic [63:0] bp_in[8];
    exp_t        bp_e[8];
    int          xs[4];
    int          ys3[5];
    int          stall_acc;
    int          in0, out0;
    logic        seen;

    initial begin
        vecs[0] = '{8'h00, 16,  pin(100, 200, -80, -200),      pout(100, 127, -80, -128)};
        vecs[1] = '{8'h02, 16,  pin(-80, -8, 0, 32),           pout(-10, -1, 0, 32)};
        vecs[2] = '{8'h00, -16, pin(100, -100, 5, -1),         pout(-100, 100, -5, 1)};
        vecs[3] = '{8'h02, 127, pin(32767, -32768, 1, -1),     pout(127, -128, 7, -1)};
        vecs[4] = '{8'h00, 1,   pin(15, -15, 16, -17),         pout(0, -1, 1, -2)};
        ys3     = '{4, 8, 2, 4, 8};

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_rdy", s_axis_tready, 0);
        check("rst_m_vld", m_axis_tvalid, 0);
        check("rst_m_dat", m_axis_tdata, 0);
        check("rst_m_last", m_axis_tlast, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("idle_s_rdy", s_axis_tready, 1);
        @(posedge aclk);
        #1;

        // 1x1 frames from the vector table; data-beat tuser is junk and must be ignored
        for (int i = 0; i < 5; i++) begin
            send_cfg(vecs[i].user, vecs[i].scale, 1'b0);
            send_beat(vecs[i].x, 8'hFF, 1'b1, 1'b1, {vecs[i].y, 1'b1});
            wait_drain();
        end

        // 3x3 frame: tlast on the header is ignored, rows wrap on the 4th data beat
        send_cfg(8'h01, 16, 1'b1);
        send_cfg(8'h00, 32, 1'b0);
        send_cfg(8'h00, 8, 1'b0);
        for (int k = 0; k < 5; k++)
            send_beat(pin(4, 4, 4, 4), 8'h00, k == 4, 1'b1,
                      {pout(ys3[k], ys3[k], ys3[k], ys3[k]), k == 4});
        wait_drain();

        // Backpressure mid-frame
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 4; c++) xs[c] = int'($urandom_range(0, 4000)) - 2000;
            bp_in[i] = pin(xs[0], xs[1], xs[2], xs[3]);
            bp_e[i]  = {pout(ref_y(xs[0], 24, 1), ref_y(xs[1], 24, 1),
                             ref_y(xs[2], 24, 1), ref_y(xs[3], 24, 1)), i == 7};
        end
        in0  = in_cnt;
        out0 = out_cnt;
        send_cfg(8'h02, 24, 1'b0);
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(bp_in[i], 8'h00, i == 7, 1'b1, bp_e[i]);
            end
            begin
                repeat (3) @(posedge aclk);
                #1 m_axis_tready = 1'b0;
                stall_acc = 0;
                repeat (5) begin
                    @(negedge aclk);
                    if (s_axis_tvalid && s_axis_tready) stall_acc++;
                end
                @(posedge aclk);
                #1 m_axis_tready = 1'b1;
            end
        join
        wait_drain();
        check("stall_accepts_le2", stall_acc <= 2, 1);
        check("bp_in_count", in_cnt - in0, 8);
        check("bp_out_count", out_cnt - out0, 8);

        // Drain: next header offered right after tlast, output held for a few cycles
        send_cfg(8'h00, 16, 1'b0);
        m_axis_tready = 1'b0;
        send_beat(pin(16, 32, -16, 1), 8'h00, 1'b1, 1'b1, {pout(16, 32, -16, 1), 1'b1});
        s_axis_tdata  = pin(16, 16, 16, 16);
        s_axis_tuser  = 8'h00;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (i == 3) m_axis_tready = 1'b1;
            @(negedge aclk);
            check("drain_s_rdy_low", s_axis_tready, 0);
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) seen = 1'b1;
            else begin
                @(posedge aclk);
                #1;
            end
        end
        check("drain_tlast_seen", seen, 1);
        @(negedge aclk);
        check("drain_s_rdy_after", s_axis_tready, 1);
        @(posedge aclk);
        #1 s_axis_tvalid = 1'b0;
        send_beat(pin(-100, 50, 300, -300), 8'hFF, 1'b1, 1'b1, {pout(-100, 50, 127, -128), 1'b1});
        wait_drain();

        // Reset while in CFG_BODY
        send_cfg(8'h01, 32, 1'b0);
        send_cfg(8'h00, 32, 1'b0);
        aresetn = 1'b0;
        @(negedge aclk);
        check("rst_body_s_rdy", s_axis_tready, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        check("rst_body_m_vld", m_axis_tvalid, 0);
        check("rst_body_s_rdy_after", s_axis_tready, 1);
        @(posedge aclk);
        #1;
        send_cfg(8'h00, 16, 1'b0);
        send_beat(pin(100, 200, -80, -200), 8'h00, 1'b1, 1'b1, {pout(100, 127, -80, -128), 1'b1});
        wait_drain();

        // Reset while in DRAIN with an output beat stalled
        send_cfg(8'h00, 16, 1'b0);
        m_axis_tready = 1'b0;
        send_beat(pin(5, 6, 7, 8), 8'h00, 1'b1, 1'b1, {pout(5, 6, 7, 8), 1'b1});
        repeat (3) @(negedge aclk);
        check("drain_pending_vld", m_axis_tvalid, 1);
        @(posedge aclk);
        #1 aresetn = 1'b0;
        sb.delete();
        @(negedge aclk);
        check("rst_drain_s_rdy", s_axis_tready, 0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        check("rst_drain_m_vld", m_axis_tvalid, 0);
        check("rst_drain_s_rdy_after", s_axis_tready, 1);
        @(posedge aclk);
        #1;
        send_cfg(8'h02, 16, 1'b0);
        send_beat(pin(-80, -8, 0, 32), 8'h00, 1'b1, 1'b1, {pout(-10, -1, 0, 32), 1'b1});
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_lrelu_seq.md
AXIS_LRELU_SEQ -- requirements
Module: axis_lrelu_seq

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- CHANNELS, 4, parallel lanes per beat.
- WORD_WIDTH_IN, 16, signed input word width.
- WORD_WIDTH_OUT, 8, signed output word width.
- WORD_WIDTH_CONFIG, 8, signed scale word width.
- TUSER_WIDTH, 8, s_axis_tuser width.
- CFG_BEATS_3X3, 3, config frame length in 3x3 mode.
- CFG_BEATS_1X1, 1, config frame length in 1x1 mode.
- SHIFT, 4, arithmetic right shift applied after scaling.
- ALPHA_SHIFT, 3, leaky slope is 2^-ALPHA_SHIFT.
- INDEX_IS_3X3, 0, tuser bit selecting the frame length.
- INDEX_IS_RELU, 1, tuser bit: 1 = leaky, 0 = linear.

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- aclk, in, 1, sole clock.
- aresetn, in, 1, reset; synchronous and active-low, sampled on rising aclk.
- s_axis_tvalid, in, 1, slave beat valid.
- s_axis_tready, out, 1, slave ready.
- s_axis_tdata, in, CHANNELS*WORD_WIDTH_IN, data or config beat; channel c occupies word c.
- s_axis_tuser, in, TUSER_WIDTH, mode bits, sampled on the config header beat.
- s_axis_tlast, in, 1, marks the last data beat of a frame.
- m_axis_tvalid, out, 1, master beat valid.
- m_axis_tready, in, 1, master ready.
- m_axis_tdata, out, CHANNELS*WORD_WIDTH_OUT, activated words.
- m_axis_tlast, out, 1, tlast delayed by the pipeline.

Function
REQ-003 SHALL use the states CFG_HDR, CFG_BODY, PASS, DRAIN; the reset state SHALL be CFG_HDR.
REQ-004 A slave handshake SHALL be s_axis_tvalid && s_axis_tready.
- s_axis_tready SHALL be 0 in DRAIN.
- s_axis_tready SHALL equal pipe_en in all other states.
REQ-005 pipe_en SHALL be !m_axis_tvalid || m_axis_tready; every pipeline register SHALL advance only when pipe_en is 1.
REQ-006 In CFG_HDR, a handshake SHALL:
- latch mode_3x3 = tuser[INDEX_IS_3X3] and mode_relu = tuser[INDEX_IS_RELU];
- write the beat into the config RAM at address 0;
- set nbeats to CFG_BEATS_3X3 or CFG_BEATS_1X1.
REQ-007 After the CFG_HDR handshake, the next state SHALL be CFG_BODY if nbeats > 1, else PASS.
REQ-008 In CFG_BODY, each handshake SHALL write the config RAM at address wr_addr (1..nbeats-1), then increment wr_addr.
- On the handshake writing address nbeats-1, the next state SHALL be PASS.
REQ-009 Config beats SHALL NOT produce output beats.
- s_axis_tlast on a config beat SHALL be ignored.
REQ-010 The config RAM SHALL have depth max(CFG_BEATS_3X3, CFG_BEATS_1X1) and width CHANNELS*WORD_WIDTH_CONFIG.
REQ-011 In PASS, each handshake SHALL enter the pipeline with scale row rd_addr.
- rd_addr SHALL increment per data beat and wrap from nbeats-1 to 0.
- rd_addr SHALL reset to 0 on entering PASS.
REQ-012 Per channel, the datapath SHALL compute:
- p = x*s, full width WORD_WIDTH_IN+WORD_WIDTH_CONFIG, signed;
- q = p >>> SHIFT;
- if mode_relu and q < 0, q = q >>> ALPHA_SHIFT;
- y = q saturated to [-2^(WORD_WIDTH_OUT-1), 2^(WORD_WIDTH_OUT-1)-1].
REQ-013 The pipeline SHALL be 2 stages:
- stage 1 registers the multiply;
- stage 2 registers shift, leak and saturate, and drives m_axis_*.
- Latency from slave handshake to m_axis_tvalid SHALL be 2 cycles with m_axis_tready held 1.
REQ-014 Throughput SHALL be one beat per cycle when m_axis_tready = 1.
- When m_axis_tready = 0, the pipeline SHALL hold, and m_axis_tdata/tlast SHALL stay stable while m_axis_tvalid is 1.
REQ-015 A PASS handshake with s_axis_tlast = 1 SHALL move the state to DRAIN.
REQ-016 DRAIN SHALL return to CFG_HDR in the cycle after the tlast beat completes its master handshake.
- Tracking SHALL use an in-flight counter, 0..2: +1 per slave data handshake, -1 per master handshake; both in one cycle leaves it unchanged.
- DRAIN SHALL exit when the counter reaches 0.
REQ-017 The mode and config RAM SHALL be overwritten only by the next config frame.
- Data in flight SHALL use the mode latched when that data was accepted.

Reset
REQ-018 With aresetn = 0 at a rising edge, the block SHALL, on that edge:
- set state = CFG_HDR;
- clear wr_addr, rd_addr, nbeats, in-flight counter, mode_3x3 and mode_relu to 0;
- set m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0.
REQ-019 s_axis_tready SHALL be 0 while aresetn = 0.
REQ-020 Reset asserted mid-frame or mid-drain SHALL discard all in-flight beats; config RAM contents need not be cleared.

Verification
REQ-021 1x1 config: header with tuser = 0b00 and scale 16 on all channels, then data x = {100, 200, -80, -200} with tlast -> out {100, 127, -80, -128} after 2 cycles, tlast = 1, state returns to CFG_HDR.
REQ-022 Leaky: header with tuser = 0b10, scale 16; x = {-80, -8, 0, 32} -> out {-10, -1, 0, 32}.
REQ-023 3x3 config: tuser = 0b01, rows scales {16, 32, 8}; five data beats all x = 4 -> outputs 4, 8, 2, 4, 8 (rd_addr wraps).
REQ-024 Backpressure: m_axis_tready = 0 for 5 cycles mid-frame -> at most 2 beats are accepted, m_axis_tdata is stable, and no beat is lost or duplicated when tready returns.
REQ-025 Drain: after tlast, a config header is offered immediately -> s_axis_tready stays 0 until the tlast output handshake, and is 1 in the next cycle.
REQ-026 Reset in CFG_BODY and in DRAIN -> the next cycle shows m_axis_tvalid = 0 and state CFG_HDR, and a new 1x1 frame processes correctly.
